alu64bit_seq: RTL and testbench

Clocked request/response front end for the combinational alu64bit. Accepts an operation over a valid/ready request port and drives the ALU operand inputs from registers. It then waits a programmable settle time for the gate-level ripple logic to resolve, captures s/cout, and returns them over a valid/ready response port. It is the consuming end of the ALU's a/b/op/cin to s/cout interface, for use in clocked datapaths and self-checking benches.

---
 rtl/alu64bit_seq.sv | 148 ++++++++++++++
 tb/tb_alu64bit_seq.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu64bit_seq.sv
// Purpose : clocked valid/ready front end around the combinational alu64bit.
// Latency : result captured SETTLE_CYCLES edges after accept (min 1); rsp_valid rises the cycle after.
// Backpr. : one op in flight; req_ready low until the response handshake, and the result is held while rsp_ready is low.
//
// Ports:
//   clk, rst                      rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready           request handshake; req_a/req_b/req_op/req_cin operands
//   rsp_valid/rsp_ready           response handshake; rsp_s/rsp_cout captured result
//   alu_a/alu_b/alu_op/alu_cin    registered operands driven into the external ALU
//   alu_s/alu_cout                ALU outputs, sampled once the settle time has elapsed
//   busy                          high whenever an operation is in flight
//   ops_done                      wrapping count of completed response handshakes
module alu64bit_seq #(
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [63:0]      req_a,
    input  logic [63:0]      req_b,
    input  logic [1:0]       req_op,
    input  logic             req_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_s,
    output logic             rsp_cout,
    output logic [63:0]      alu_a,
    output logic [63:0]      alu_b,
    output logic [1:0]       alu_op,
    output logic             alu_cin,
    input  logic [63:0]      alu_s,
    input  logic             alu_cout,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    // A settle time of zero still needs one edge between launch and capture.
    localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int SW         = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
    localparam logic [SW-1:0] CNT_LOAD = SW'(SETTLE_EFF - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     cnt_q, cnt_d;
    logic [63:0]       alu_a_q, alu_a_d;
    logic [63:0]       alu_b_q, alu_b_d;
    logic [1:0]        alu_op_q, alu_op_d;
    logic              alu_cin_q, alu_cin_d;
    logic [63:0]       rsp_s_q, rsp_s_d;
    logic              rsp_cout_q, rsp_cout_d;
    logic [CNT_W-1:0]  ops_q, ops_d;

    logic accept;
    logic rsp_hs;

    // req_ready is gated by rst directly so nothing is accepted while reset is held.
    assign req_ready = (state_q == IDLE) & ~rst;
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);

    assign accept = req_valid & req_ready;
    assign rsp_hs = rsp_valid & rsp_ready;

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_op   = alu_op_q;
    assign alu_cin  = alu_cin_q;
    assign rsp_s    = rsp_s_q;
    assign rsp_cout = rsp_cout_q;
    assign ops_done = ops_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        alu_cin_d  = alu_cin_q;
        rsp_s_d    = rsp_s_q;
        rsp_cout_d = rsp_cout_q;
        ops_d      = ops_q;

        case (state_q)
            IDLE: begin
                // Operands only move here, so the ALU inputs stay frozen
                // for the whole settle and response window.
                if (accept) begin
                    alu_a_d   = req_a;
                    alu_b_d   = req_b;
                    alu_op_d  = req_op;
                    alu_cin_d = req_cin;
                    cnt_d     = CNT_LOAD;
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    rsp_s_d    = alu_s;
                    rsp_cout_d = alu_cout;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q - SW'(1);
                end
            end
            RESP: begin
                if (rsp_hs) begin
                    ops_d   = ops_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            alu_cin_q  <= 1'b0;
            rsp_s_q    <= '0;
            rsp_cout_q <= 1'b0;
            ops_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            alu_cin_q  <= alu_cin_d;
            rsp_s_q    <= rsp_s_d;
            rsp_cout_q <= rsp_cout_d;
            ops_q      <= ops_d;
        end
    end

endmodule

// File: tb/tb_alu64bit_seq.sv
// Bench for alu64bit_seq: three instances (settle 16 / settle 0 / 4-bit counter),
// each wired to a behavioural ALU. Expected results are queued at accept and
// compared at the response handshake.
module tb_alu64bit_seq;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  op;
        logic        cin;
        logic [63:0] exp_s;
        logic        exp_cout;
    } vec_t;

    logic              clk;
    logic              rst;
    logic [63:0]       req_a, req_b;
    logic [1:0]        req_op;
    logic              req_cin;
    logic [2:0]        qv_in, qr, rv, rr_in, rc, acin, acout, busy;
    logic [2:0][63:0]  rs, aa, ab, as_;
    logic [2:0][1:0]   aop;
    logic [2:0][15:0]  od;
    logic [3:0]        od4;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int sel = 0;
    int acc_cyc = 0, hs_cyc = 0, acc_count = 0, hs_count = 0, rises = 0;
    int lat_tab [3] = '{17, 2, 4};  // accept-sampling negedge to first rsp_valid negedge
    logic [63:0] acc_a = '0;
    logic [63:0] last_s = '0;
    logic        last_c = 1'b0;
    logic        rv_prev = 1'b0;
    logic [64:0] exp_q [$];

    function automatic logic [64:0] alu_model(input logic [63:0] a, input logic [63:0] b,
                                              input logic [1:0] op, input logic cin);
        logic [64:0] r;
        case (op)
            2'b00:   r = {1'b0, a & b};
            2'b01:   r = {1'b0, a | b};
            2'b10:   r = {1'b0, a} + {1'b0, b} + {64'd0, cin};
            default: r = {1'b0, a ^ b};
        endcase
        return r;
    endfunction

    assign {acout[0], as_[0]} = alu_model(aa[0], ab[0], aop[0], acin[0]);
    assign {acout[1], as_[1]} = alu_model(aa[1], ab[1], aop[1], acin[1]);
    assign {acout[2], as_[2]} = alu_model(aa[2], ab[2], aop[2], acin[2]);
    assign od[2] = {12'd0, od4};

    alu64bit_seq #(.SETTLE_CYCLES(16), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .req_valid(qv_in[0]), .req_ready(qr[0]),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_cin(req_cin),
        .rsp_valid(rv[0]), .rsp_ready(rr_in[0]), .rsp_s(rs[0]), .rsp_cout(rc[0]),
        .alu_a(aa[0]), .alu_b(ab[0]), .alu_op(aop[0]), .alu_cin(acin[0]),
        .alu_s(as_[0]), .alu_cout(acout[0]), .busy(busy[0]), .ops_done(od[0]));

    alu64bit_seq #(.SETTLE_CYCLES(0), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .req_valid(qv_in[1]), .req_ready(qr[1]),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_cin(req_cin),
        .rsp_valid(rv[1]), .rsp_ready(rr_in[1]), .rsp_s(rs[1]), .rsp_cout(rc[1]),
        .alu_a(aa[1]), .alu_b(ab[1]), .alu_op(aop[1]), .alu_cin(acin[1]),
        .alu_s(as_[1]), .alu_cout(acout[1]), .busy(busy[1]), .ops_done(od[1]));

    alu64bit_seq #(.SETTLE_CYCLES(3), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .req_valid(qv_in[2]), .req_ready(qr[2]),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_cin(req_cin),
        .rsp_valid(rv[2]), .rsp_ready(rr_in[2]), .rsp_s(rs[2]), .rsp_cout(rc[2]),
        .alu_a(aa[2]), .alu_b(ab[2]), .alu_op(aop[2]), .alu_cin(acin[2]),
        .alu_s(as_[2]), .alu_cout(acout[2]), .busy(busy[2]), .ops_done(od4));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (got timeout, expected event)", nm);
    endtask

    // Scoreboard / protocol monitor on the selected instance, sampled at negedge.
    always @(negedge clk) begin
        logic [64:0] e;
        cyc = cyc + 1;
        if (!rst) begin
            if (qv_in[sel] && qr[sel]) begin
                exp_q.push_back(alu_model(req_a, req_b, req_op, req_cin));
                acc_a = req_a;
                acc_cyc = cyc;
                acc_count++;
            end
            if (busy[sel])
                chk("alu_a_stable", 128'(aa[sel]), 128'(acc_a));
            if (rv[sel] && !rv_prev) begin
                chk("latency", 128'(cyc - acc_cyc), 128'(lat_tab[sel]));
                rises++;
            end
            if (rv[sel] && rr_in[sel]) begin
                if (exp_q.size() == 0) begin
                    tmo("sb_underflow");
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_s", 128'(rs[sel]), 128'(e[63:0]));
                    chk("rsp_cout", 128'(rc[sel]), 128'(e[64]));
                end
                last_s = rs[sel];
                last_c = rc[sel];
                hs_cyc = cyc;
                hs_count++;
            end
            rv_prev = rv[sel];
        end else begin
            rv_prev = 1'b0;
        end
    end

    task automatic drive(input vec_t v);
        req_a = v.a; req_b = v.b; req_op = v.op; req_cin = v.cin;
    endtask

    task automatic wait_accept(input int d);
        bit ok = 0;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            if (qr[d]) ok = 1;
        end
        if (!ok) tmo("accept");
    endtask

    task automatic wait_hs(input int n);
        bit ok = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(posedge clk);
            if (hs_count > n) ok = 1;
        end
        if (!ok) tmo("response");
        #1;
    endtask

    // Ends 1 time unit after the response handshake edge.
    task automatic do_op(input int d, input vec_t v);
        int n;
        n = hs_count;
        @(posedge clk); #1;
        drive(v);
        qv_in[d] = 1'b1;
        wait_accept(d);
        @(posedge clk); #1;
        qv_in[d] = 1'b0;
        wait_hs(n);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    vec_t tbl [6];
    vec_t v;
    logic [63:0] held_s;
    int n, a0, r0;
    bit ok;

    initial begin
        tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2'b10, 1'b0, 64'h0, 1'b1};
        tbl[1] = '{64'h1, 64'h2, 2'b10, 1'b1, 64'h4, 1'b0};
        tbl[2] = '{64'hF0F0_F0F0_F0F0_F0F0, 64'h0FF0_0FF0_0FF0_0FF0, 2'b00, 1'b0, 64'h00F0_00F0_00F0_00F0, 1'b0};
        tbl[3] = '{64'h1234_0000_0000_0000, 64'h0000_0000_0000_5678, 2'b01, 1'b1, 64'h1234_0000_0000_5678, 1'b0};
        tbl[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 2'b11, 1'b0, 64'hFEDC_BA98_7654_3210, 1'b0};
        tbl[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b10, 1'b1, 64'h1, 1'b1};

        rst = 1'b0; qv_in = '0; rr_in = '1;
        req_a = '0; req_b = '0; req_op = '0; req_cin = 1'b0;

        // Reset asserted between edges: outputs are zero without any clock edge.
        #1 rst = 1'b1;
        #1;
        chk("rst_req_ready", 128'(qr), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_rsp_valid", 128'(rv), 128'(0));
        chk("rst_ops_done", 128'(od[0]), 128'(0));
        chk("rst_alu_a", 128'(aa[0]), 128'(0));
        chk("rst_rsp_s", 128'(rs[0]), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", 128'(qr[0]), 128'(1));
        chk("post_rst_busy", 128'(busy[0]), 128'(0));

        // Vector table through the 16-cycle instance.
        for (int i = 0; i < 6; i++) begin
            do_op(0, tbl[i]);
            chk("tbl_s", 128'(last_s), 128'(tbl[i].exp_s));
            chk("tbl_cout", 128'(last_c), 128'(tbl[i].exp_cout));
            chk("tbl_ops_done", 128'(od[0]), 128'(i + 1));
            chk("tbl_idle", 128'(busy[0]), 128'(0));
        end

        // Backpressure: result held 10 cycles, a stray request is ignored.
        do_reset();
        n = hs_count;
        @(posedge clk); #1;
        drive(tbl[3]);
        rr_in[0] = 1'b0;
        qv_in[0] = 1'b1;
        wait_accept(0);
        @(posedge clk); #1;
        qv_in[0] = 1'b0;
        ok = 0;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            if (rv[0]) ok = 1;
        end
        if (!ok) tmo("bp_rsp_valid");
        held_s = rs[0];
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            qv_in[0] = (c == 3);
            req_a = (c == 3) ? 64'hDEAD_BEEF_0000_0001 : tbl[3].a;
            @(negedge clk);
            chk("bp_rsp_valid", 128'(rv[0]), 128'(1));
            chk("bp_rsp_s", 128'(rs[0]), 128'(held_s));
            chk("bp_req_ready", 128'(qr[0]), 128'(0));
            chk("bp_alu_a", 128'(aa[0]), 128'(tbl[3].a));
        end
        @(posedge clk); #1;
        qv_in[0] = 1'b0;
        req_a = tbl[3].a;
        rr_in[0] = 1'b1;
        wait_hs(n);
        chk("bp_idle", 128'(busy[0]), 128'(0));
        chk("bp_ops_done", 128'(od[0]), 128'(1));
        chk("bp_s", 128'(last_s), 128'(tbl[3].exp_s));

        // Back-to-back with req_valid held high.
        do_reset();
        n = hs_count;
        a0 = acc_count;
        @(posedge clk); #1;
        drive(tbl[1]);
        qv_in[0] = 1'b1;
        wait_accept(0);
        @(posedge clk); #1;
        drive(tbl[4]);
        wait_hs(n);
        chk("b2b_ops_done_1", 128'(od[0]), 128'(1));
        chk("b2b_s_1", 128'(last_s), 128'(tbl[1].exp_s));
        ok = 0;
        for (int k = 0; k < 10 && !ok; k++) begin
            @(posedge clk);
            if (acc_count > a0 + 1) ok = 1;
        end
        if (!ok) tmo("b2b_second_accept");
        chk("b2b_accept_gap", 128'(acc_cyc - hs_cyc), 128'(1));
        #1 qv_in[0] = 1'b0;
        wait_hs(n + 1);
        chk("b2b_ops_done_2", 128'(od[0]), 128'(2));
        chk("b2b_s_2", 128'(last_s), 128'(tbl[4].exp_s));

        // Reset in the 5th settle cycle discards the operation.
        @(posedge clk); #1;
        drive(tbl[0]);
        qv_in[0] = 1'b1;
        wait_accept(0);
        @(posedge clk); #1;
        qv_in[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        exp_q.delete();
        r0 = rises;
        #1;
        chk("mid_rst_busy", 128'(busy[0]), 128'(0));
        chk("mid_rst_alu_a", 128'(aa[0]), 128'(0));
        chk("mid_rst_ops_done", 128'(od[0]), 128'(0));
        chk("mid_rst_req_ready", 128'(qr[0]), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_rst_no_rsp", 128'(rises), 128'(r0));
        chk("mid_rst_ops_done_after", 128'(od[0]), 128'(0));
        chk("mid_rst_alu_a_after", 128'(aa[0]), 128'(0));
        do_op(0, tbl[5]);
        chk("mid_rst_fresh_s", 128'(last_s), 128'(tbl[5].exp_s));
        chk("mid_rst_fresh_cout", 128'(last_c), 128'(tbl[5].exp_cout));
        chk("mid_rst_fresh_ops", 128'(od[0]), 128'(1));

        // SETTLE_CYCLES=0 behaves as 1 (latency checked by the monitor).
        sel = 1;
        do_op(1, tbl[1]);
        chk("s0_s", 128'(last_s), 128'(tbl[1].exp_s));
        chk("s0_ops_done", 128'(od[1]), 128'(1));

        // CNT_W=4 wraps after 16 completions.
        sel = 2;
        for (int k = 0; k < 17; k++) begin
            v = '{64'(k), 64'h1, 2'b10, 1'b0, 64'(k + 1), 1'b0};
            do_op(2, v);
            if (k == 15) chk("wrap_16", 128'(od[2]), 128'(0));
        end
        chk("wrap_17", 128'(od[2]), 128'(1));
        chk("wrap_17_s", 128'(last_s), 128'(64'd17));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
